// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: request/acknowledge bus between the MEM-stage access
// controller (master) and a variable-latency 32-bit data memory (slave).
// Read data is qualified by MemAckIn in the same cycle.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              MemReqOut;
  logic              MemWeOut;
  logic [ADDR_W-1:0] MemAddrOut;
  logic [3:0]        MemByteEnOut;
  logic [31:0]       MemWDataOut;
  logic              MemAckIn;
  logic [31:0]       MemRDataIn;

  modport master (
    output MemReqOut, MemWeOut, MemAddrOut, MemByteEnOut, MemWDataOut,
    input  MemAckIn, MemRDataIn
  );

  modport slave (
    input  MemReqOut, MemWeOut, MemAddrOut, MemByteEnOut, MemWDataOut,
    output MemAckIn, MemRDataIn
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage memory access controller.
// Takes the EX/MEM memory control (read/write, size, address, store data),
// runs one req/ack transaction on the data memory, aligns store data into
// byte lanes, extracts and extends load data, and stalls the pipeline until
// the access completes (IDLE -> BUSY -> DONE -> IDLE).
// Optional feature: define MEM_ACK_TIMEOUT_EN to add an ack watchdog that
// abandons a request after TIMEOUT_CYCLES busy cycles and reports an error
// with LoadDataOut = 0xFFFFFFFF.
module mem_access_ctrl #(
  parameter int ADDR_W         = 32,
  parameter bit CHECK_ALIGN    = 1'b1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              MemReadIn,
  input  logic              MemWriteIn,
  input  logic [1:0]        bytes2LoadIn,
  input  logic [1:0]        bytes2StoreIn,
  input  logic              LoadUnsignedIn,
  input  logic [ADDR_W-1:0] ALUResultIn,
  input  logic [31:0]       MemWriteDataIn,
  mem_access_ctrl_if.master mem,
  output logic [31:0]       LoadDataOut,
  output logic              MemStallOut,
  output logic              AccessErrOut
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [1:0]        lsize_q;
  logic              uns_q;
  logic [1:0]        lane_q;
  logic [31:0]       load_q;
  logic              err_q;

  logic [1:0]  size;
  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        misaligned;
  logic        op_valid;
  logic        op_legal;
  logic        start;
  logic        op_err;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] load_d;
  logic [7:0]  wlane [4];
  logic [7:0]  rd_byte [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

`ifdef MEM_ACK_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q;
`else
  // Watchdog is compiled out; keep the parameter referenced.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Decode the pending operation: size, alignment legality, and start/error.
  always_comb begin
    size       = MemWriteIn ? bytes2StoreIn : bytes2LoadIn;
    is_half    = (size == 2'b01);
    is_byte    = (size == 2'b10);
    is_word    = !is_half && !is_byte;
    misaligned = 1'b0;
    if (CHECK_ALIGN) begin
      if (is_word) begin
        misaligned = |ALUResultIn[1:0];
      end else if (is_half) begin
        misaligned = ALUResultIn[0];
      end
    end
    op_valid = MemReadIn | MemWriteIn;
    op_legal = !(MemReadIn && MemWriteIn) && !misaligned;
    start    = (state_q == IDLE) && op_valid && op_legal;
    op_err   = (state_q == IDLE) && op_valid && !op_legal;
  end

  // Byte-lane enables for the addressed bytes (little-endian lanes).
  always_comb begin
    be_d = 4'b1111;
    if (is_half) begin
      be_d = ALUResultIn[1] ? 4'b1100 : 4'b0011;
    end else if (is_byte) begin
      be_d = 4'b0001 << ALUResultIn[1:0];
    end
  end

  // Store data is replicated into every lane; read word is split into bytes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wlane[gi]   = is_byte ? MemWriteDataIn[7:0] :
                         is_half ? MemWriteDataIn[8*(gi%2) +: 8] :
                                   MemWriteDataIn[8*gi +: 8];
    assign rd_byte[gi] = mem.MemRDataIn[8*gi +: 8];
  end
  assign wdata_d = {wlane[3], wlane[2], wlane[1], wlane[0]};

  // Pick the addressed lane of the read word and sign/zero-extend it.
  always_comb begin
    sel_byte = rd_byte[lane_q];
    sel_half = lane_q[1] ? {rd_byte[3], rd_byte[2]} : {rd_byte[1], rd_byte[0]};
    case (lsize_q)
      2'b10:   load_d = {{24{!uns_q & sel_byte[7]}}, sel_byte};
      2'b01:   load_d = {{16{!uns_q & sel_half[15]}}, sel_half};
      default: load_d = mem.MemRDataIn;
    endcase
  end

  // Access FSM: latch the op in IDLE, hold the request in BUSY until ack
  // (or watchdog expiry), then one DONE cycle lets the pipeline advance.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
      lsize_q <= 2'b00;
      uns_q   <= 1'b0;
      lane_q  <= 2'b00;
      load_q  <= 32'h0;
      err_q   <= 1'b0;
`ifdef MEM_ACK_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q  <= {ALUResultIn[ADDR_W-1:2], 2'b00};
            we_q    <= MemWriteIn;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            lsize_q <= bytes2LoadIn;
            uns_q   <= LoadUnsignedIn;
            lane_q  <= ALUResultIn[1:0];
            req_q   <= 1'b1;
            state_q <= BUSY;
`ifdef MEM_ACK_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end else if (op_err) begin
            err_q  <= 1'b1;
            load_q <= 32'h0;
          end
        end
        BUSY: begin
          if (mem.MemAckIn) begin
            if (!we_q) begin
              load_q <= load_d;
            end
            req_q   <= 1'b0;
            state_q <= DONE;
          end
`ifdef MEM_ACK_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            load_q  <= 32'hFFFF_FFFF;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Stall while an op starts or is in flight; released in DONE and in reset.
  assign MemStallOut = Rst_n & (start | (state_q == BUSY));

  assign mem.MemReqOut    = req_q;
  assign mem.MemWeOut     = we_q;
  assign mem.MemAddrOut   = addr_q;
  assign mem.MemByteEnOut = be_q;
  assign mem.MemWDataOut  = wdata_q;
  assign LoadDataOut      = load_q;
  assign AccessErrOut     = err_q;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Turns the latched memory control (read/write, access size, address, store data) into a req/ack transaction on a variable-latency 32-bit data memory.
- Aligns store data into byte lanes, extracts and extends load data, and holds the pipeline with a stall until the access completes.

Parameters:
- ADDR_W, 32, byte-address width of ALUResultIn and MemAddrOut.
- CHECK_ALIGN, 1, 1 = misaligned half/word accesses are flagged and suppressed; 0 = low address bits ignored for half/word.
- TIMEOUT_CYCLES, 255, ack watchdog limit; used only with MEM_ACK_TIMEOUT_EN.

Ports:
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous active-low reset
- MemReadIn  in  1  load pending in MEM stage
- MemWriteIn  in  1  store pending in MEM stage
- bytes2LoadIn  in  2  load size: 00 word, 01 half, 10 byte, 11 treated as word
- bytes2StoreIn  in  2  store size, same encoding
- LoadUnsignedIn  in  1  1 = zero-extend sub-word load, 0 = sign-extend
- ALUResultIn  in  ADDR_W  byte address
- MemWriteDataIn  in  32  store data, right-justified
- MemReqOut  out  1  request to data memory
- MemWeOut  out  1  1 = write, 0 = read
- MemAddrOut  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
- MemByteEnOut  out  4  lane enables
- MemWDataOut  out  32  lane-aligned store data
- MemAckIn  in  1  memory completion; read data valid same cycle
- MemRDataIn  in  32  read word
- LoadDataOut  out  32  extended load result, to MEM/WB
- MemStallOut  out  1  hold PC, IF/ID, ID/EX, EX/MEM; EX/MEM holds contents, it does not flush
- AccessErrOut  out  1  one-cycle pulse: misaligned access or MemRead&MemWrite both set

Behaviour:
- Reset values: all outputs 0; FSM in IDLE.
- Op valid = MemReadIn | MemWriteIn.
- Lanes are little-endian: byte k = bits 8k+7:8k, lane = addr[1:0].
- Byte enables:
  - word: 1111
  - half: 0011 << 2*addr[1]
  - byte: 0001 << addr[1:0]
- MemWDataOut = store data replicated into every lane (byte x4, half x2, word x1).
- Load extraction selects the addressed lane, then sign- or zero-extends per LoadUnsignedIn.
- FSM states: IDLE, BUSY, DONE.
- IDLE, op valid and legal:
  - latch address, write flag, byte enables and write data;
  - MemReqOut=1 registered; go to BUSY.
  - MemStallOut=1 combinationally in this cycle.
- IDLE, op illegal (misaligned with CHECK_ALIGN=1, or both read and write set):
  - no request; AccessErrOut pulses 1 cycle; MemStallOut=0; LoadDataOut=0.
- BUSY: MemReqOut held with stable addr/data/enables until MemAckIn; MemStallOut=1.
- BUSY & MemAckIn:
  - load: register extracted data into LoadDataOut;
  - MemReqOut drops at the next edge; go to DONE.
- DONE: MemStallOut=0, so the pipeline advances on this edge; LoadDataOut valid; go to IDLE unconditionally.
  - The same instruction is never re-issued.
- Minimum latency: ack in the first BUSY cycle gives 2 stall cycles per memory op.
- Stores leave LoadDataOut unchanged.
- Non-memory instructions never stall.
- Back-to-back memory ops: the second op is seen in IDLE after DONE; no bubble cycle is inserted.
- MemAckIn in IDLE or DONE is ignored.
- Reset mid-access: immediate return to IDLE; MemReqOut and MemStallOut go to 0; the memory must tolerate an abandoned request.

Optional Feature:
- Macro MEM_ACK_TIMEOUT_EN.
- Defined: an 8+ bit counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES without ack: drop MemReqOut, pulse AccessErrOut, LoadDataOut=0xFFFFFFFF, go to DONE.
- Undefined: no counter; BUSY waits indefinitely.

Test Plan:
- lw addr 0x100, ack after 3 BUSY cycles, RData 0xDEADBEEF -> MemReq high 3 cycles, ByteEn 1111, Addr 0x100, stall 4 cycles, LoadDataOut 0xDEADBEEF in DONE.
- lb signed addr 0x103, RData 0x80112233 -> LoadDataOut 0xFFFFFF80; same access as lbu -> 0x00000080.
- sh addr 0x22, data 0x0000ABCD, immediate ack -> MemWe 1, ByteEn 1100, WData 0xABCDABCD, Addr 0x20, stall 2 cycles.
- lw addr 0x102 with CHECK_ALIGN=1 -> no MemReq, AccessErrOut 1-cycle pulse, no stall.
- Rst_n low during BUSY -> MemReqOut and MemStallOut go to 0 asynchronously; next lw after release completes normally.
- MEM_ACK_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, ack never arrives -> request dropped after 4 BUSY cycles, AccessErrOut pulse, LoadDataOut 0xFFFFFFFF.
